// File: rtl/gs_pkg.sv
// Shared types for the GS/loader SDRAM arbiter: FSM states, requester IDs
// and the widths used to pad requester addresses onto the controller bus.
package gs_pkg;

   localparam int LD_AW  = 15;
   localparam int GS_AW  = 21;
   localparam int MEM_AW = 25;
   localparam int DW     = 8;
   localparam int LD_PAD = MEM_AW - LD_AW;
   localparam int GS_PAD = MEM_AW - GS_AW;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } gs_state_e;

   typedef enum logic [1:0] {
      ID_RFSH = 2'd0,
      ID_LD   = 2'd1,
      ID_GS   = 2'd2
   } gs_req_id_e;

   function automatic logic [MEM_AW-1:0] pad_ld(input logic [LD_AW-1:0] a);
      return {{LD_PAD{1'b0}}, a};
   endfunction

   function automatic logic [MEM_AW-1:0] pad_gs(input logic [GS_AW-1:0] a);
      return {{GS_PAD{1'b0}}, a};
   endfunction

endpackage

// File: rtl/gs_rfsh_timer.sv
// Refresh interval timer: counts 0..RFSH_PERIOD-1 while enabled, pulses
// wrap on the terminal count, and sits at zero whenever disabled.
module gs_rfsh_timer #(
   parameter int RFSH_PERIOD = 512
) (
   input  logic clk_sys,
   input  logic areset_n,
   input  logic enable,
   output logic wrap
);

   localparam int CW = (RFSH_PERIOD > 2) ? $clog2(RFSH_PERIOD) : 1;
   localparam logic [CW-1:0] TC = CW'(RFSH_PERIOD - 1);

   logic [CW-1:0] cnt_q;

   assign wrap = enable && (cnt_q == TC);

   always_ff @(posedge clk_sys or negedge areset_n) begin
      if (!areset_n) begin
         cnt_q <= '0;
      end else if (!enable || wrap) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/gs_sdram_arb.sv
// Arbitrates refresh, loader writes and GS accesses onto a single SDRAM
// controller command port, one command at a time.
//
// state | meaning
// IDLE  | waiting for a pending request and mem_idle
// ISSUE | one-cycle command pulse on mem_wr/mem_rd/mem_rfsh
// WAIT  | minimum busy time, then wait for mem_idle
// DONE  | completion: ld_ack / gs_din update / gs_wait release
module gs_sdram_arb
   import gs_pkg::*;
#(
   parameter int RFSH_PERIOD = 512,
   parameter int MIN_BUSY    = 2
) (
   input  logic              clk_sys,
   input  logic              areset_n,
   input  logic              ld_act,
   input  logic              ld_req,
   input  logic [LD_AW-1:0]  ld_a,
   input  logic [DW-1:0]     ld_d,
   output logic              ld_ack,
   input  logic              gs_rd_n,
   input  logic              gs_wr_n,
   input  logic [GS_AW-1:0]  gs_a,
   input  logic [DW-1:0]     gs_dout,
   output logic [DW-1:0]     gs_din,
   output logic              gs_wait,
   input  logic              gs_rfsh_n,
   output logic [MEM_AW-1:0] mem_a,
   output logic [DW-1:0]     mem_di,
   output logic              mem_wr,
   output logic              mem_rd,
   output logic              mem_rfsh,
   input  logic [DW-1:0]     mem_do,
   input  logic              mem_idle
);

   localparam int BW = (MIN_BUSY > 2) ? $clog2(MIN_BUSY) : 1;
   localparam logic [BW-1:0] BUSY_LOAD = (MIN_BUSY > 0) ? BW'(MIN_BUSY - 1) : '0;

   gs_state_e   state_q;
   gs_req_id_e  cur_id_q;
   gs_req_id_e  grant_id;
   logic        cur_rd_q;
   logic [BW-1:0] busy_q;

   logic        rd_n_q, wr_n_q, rfsh_n_q;
   logic        rfsh_pend_q, ld_pend_q, gs_pend_q, gs_wr_q;
   logic [LD_AW-1:0] ld_a_q;
   logic [DW-1:0]    ld_d_q, gs_d_q;
   logic [GS_AW-1:0] gs_a_q;

   logic [MEM_AW-1:0] mem_a_q;
   logic [DW-1:0]     mem_di_q, gs_din_q;
   logic              mem_wr_q, mem_rd_q, mem_rfsh_q, ld_ack_q, gs_wait_q;

   logic tmr_wrap, rd_fall, wr_fall, rfsh_fall;
   logic gs_new, rfsh_new, grant, grant_rfsh, grant_ld, grant_gs;
   logic ld_accept, gs_accept;

   gs_rfsh_timer #(.RFSH_PERIOD(RFSH_PERIOD)) u_tmr (
      .clk_sys  (clk_sys),
      .areset_n (areset_n),
      .enable   (ld_act),
      .wrap     (tmr_wrap)
   );

   assign rd_fall   = rd_n_q & ~gs_rd_n;
   assign wr_fall   = wr_n_q & ~gs_wr_n;
   assign rfsh_fall = rfsh_n_q & ~gs_rfsh_n;
   assign gs_new    = ~ld_act & (rd_fall | wr_fall);
   assign rfsh_new  = (~ld_act & rfsh_fall) | tmr_wrap;

   assign grant = (state_q == ST_IDLE) && mem_idle &&
                  (rfsh_pend_q || ld_pend_q || gs_pend_q);

   always_comb begin
      grant_id = ID_GS;
      if (rfsh_pend_q)    grant_id = ID_RFSH;
      else if (ld_pend_q) grant_id = ID_LD;
   end

   assign grant_rfsh = grant && (grant_id == ID_RFSH);
   assign grant_ld   = grant && (grant_id == ID_LD);
   assign grant_gs   = grant && (grant_id == ID_GS);

   // A request landing on its own grant cycle re-arms the flag for later.
   assign ld_accept = ld_req && (!ld_pend_q || grant_ld);
   assign gs_accept = gs_new && (!gs_pend_q || grant_gs);

   always_ff @(posedge clk_sys or negedge areset_n) begin
      if (!areset_n) begin
         rd_n_q      <= 1'b1;
         wr_n_q      <= 1'b1;
         rfsh_n_q    <= 1'b1;
         rfsh_pend_q <= 1'b0;
         ld_pend_q   <= 1'b0;
         gs_pend_q   <= 1'b0;
         gs_wr_q     <= 1'b0;
         ld_a_q      <= '0;
         ld_d_q      <= '0;
         gs_a_q      <= '0;
         gs_d_q      <= '0;
      end else begin
         rd_n_q   <= gs_rd_n;
         wr_n_q   <= gs_wr_n;
         rfsh_n_q <= gs_rfsh_n;

         if (rfsh_new)        rfsh_pend_q <= 1'b1;
         else if (grant_rfsh) rfsh_pend_q <= 1'b0;

         if (ld_accept) begin
            ld_pend_q <= 1'b1;
            ld_a_q    <= ld_a;
            ld_d_q    <= ld_d;
         end else if (grant_ld) begin
            ld_pend_q <= 1'b0;
         end

         if (gs_accept) begin
            gs_pend_q <= 1'b1;
            gs_wr_q   <= wr_fall;
            gs_a_q    <= gs_a;
            gs_d_q    <= gs_dout;
         end else if (grant_gs) begin
            gs_pend_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk_sys or negedge areset_n) begin
      if (!areset_n) begin
         state_q    <= ST_IDLE;
         cur_id_q   <= ID_RFSH;
         cur_rd_q   <= 1'b0;
         busy_q     <= '0;
         mem_a_q    <= '0;
         mem_di_q   <= '0;
         mem_wr_q   <= 1'b0;
         mem_rd_q   <= 1'b0;
         mem_rfsh_q <= 1'b0;
         ld_ack_q   <= 1'b0;
         gs_din_q   <= 8'hFF;
         gs_wait_q  <= 1'b0;
      end else begin
         mem_wr_q   <= 1'b0;
         mem_rd_q   <= 1'b0;
         mem_rfsh_q <= 1'b0;
         ld_ack_q   <= 1'b0;

         case (state_q)
            ST_IDLE: begin
               if (grant) begin
                  state_q  <= ST_ISSUE;
                  cur_id_q <= grant_id;
                  cur_rd_q <= 1'b0;
                  case (grant_id)
                     ID_RFSH: begin
                        mem_rfsh_q <= 1'b1;
                        mem_a_q    <= '0;
                        mem_di_q   <= '0;
                     end
                     ID_LD: begin
                        mem_wr_q <= 1'b1;
                        mem_a_q  <= pad_ld(ld_a_q);
                        mem_di_q <= ld_d_q;
                     end
                     default: begin
                        mem_wr_q <= gs_wr_q;
                        mem_rd_q <= ~gs_wr_q;
                        cur_rd_q <= ~gs_wr_q;
                        mem_a_q  <= pad_gs(gs_a_q);
                        mem_di_q <= gs_d_q;
                     end
                  endcase
               end
            end
            ST_ISSUE: begin
               state_q <= ST_WAIT;
               busy_q  <= BUSY_LOAD;
            end
            ST_WAIT: begin
               if (busy_q == '0) begin
                  if (mem_idle) state_q <= ST_DONE;
               end else begin
                  busy_q <= busy_q - 1'b1;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               if (cur_id_q == ID_LD) ld_ack_q <= 1'b1;
               if (cur_id_q == ID_GS && cur_rd_q) gs_din_q <= mem_do;
            end
            default: state_q <= ST_IDLE;
         endcase

         if (gs_accept)
            gs_wait_q <= 1'b1;
         else if (state_q == ST_DONE && cur_id_q == ID_GS)
            gs_wait_q <= 1'b0;
      end
   end

   assign mem_a    = mem_a_q;
   assign mem_di   = mem_di_q;
   assign mem_wr   = mem_wr_q;
   assign mem_rd   = mem_rd_q;
   assign mem_rfsh = mem_rfsh_q;
   assign ld_ack   = ld_ack_q;
   assign gs_din   = gs_din_q;
   assign gs_wait  = gs_wait_q;

endmodule
